l2_request_arbiter: RTL and testbench
=====================================

# l2_request_arbiter

Parametrised arbitration stage at the head of the L2 pipeline. It selects one request per cycle from NUM_REQUESTERS core ports or from the memory-interface restart (fill) port and presents it registered to the tag stage. Core ports are served round-robin, with arbitrary N (not limited to powers of two). Restarts have priority, bounded by a programmable burst limit so that core traffic cannot be starved by back-to-back fills.

## Interface
- NUM_REQUESTERS, 4: number of core request ports (≥1, any value).
- PACKET_WIDTH, 128: bits per request packet.
- DATA_WIDTH, 512: fill data width (one cache line).
- RESTART_BURST_MAX, 4: maximum number of consecutive restart grants while any core request is pending (≥1).

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQUESTERS  per-core request valid.
- req_packet  in  NUM_REQUESTERS*PACKET_WIDTH  per-core packets; port i occupies bits [i*PACKET_WIDTH +: PACKET_WIDTH].
- req_ready  out  NUM_REQUESTERS  per-core accept, combinational; one-hot or zero.
- restart_valid  in  1  restarted request from the memory interface.
- restart_packet  in  PACKET_WIDTH  restarted request packet.
- restart_data  in  DATA_WIDTH  line data fetched from memory.
- restart_is_flush  in  1  restart is a flush completion, not a fill.
- restart_ready  out  1  restart accepted this cycle, combinational.
- stall  in  1  downstream hold.
- arb_valid  out  1  registered output valid.
- arb_packet  out  PACKET_WIDTH  registered selected packet.
- arb_data  out  DATA_WIDTH  registered fill data; 0 for core grants.
- arb_is_fill  out  1  registered: the grant came from the restart port.
- arb_is_restarted_flush  out  1  registered copy of restart_is_flush; 0 for core grants.
- arb_source  out  max(1,$clog2(NUM_REQUESTERS))  registered index of the granted core; 0 for restart grants.
- perf_core_grant  out  1  single-cycle pulse, registered with arb_valid.
- perf_restart_grant  out  1  single-cycle pulse, registered with arb_valid.

## Operation
- State: rr_ptr (core index, 0..N-1) and burst_cnt (0..RESTART_BURST_MAX).
- Core pending: any bit of req_valid is high.
- Force-core condition: burst_cnt == RESTART_BURST_MAX and core pending.
- Grant decision, evaluated each cycle when stall = 0:
  - restart_valid and not force-core: grant the restart. burst_cnt increments, saturating at RESTART_BURST_MAX.
  - Otherwise, if a core is pending: grant the first valid core scanning rr_ptr, rr_ptr+1, … modulo N. rr_ptr becomes (granted+1) mod N, with explicit wrap from N-1 to 0. burst_cnt clears to 0.
  - Otherwise: no grant. burst_cnt clears to 0 when restart_valid = 0.
- If no core is pending, restarts are always granted; burst_cnt stays saturated.
- req_ready[i] / restart_ready assert only for the granted source. A transfer happens when valid & ready are both high.
- When stall = 1:
  - all readies are 0;
  - rr_ptr and burst_cnt hold;
  - all arb_* outputs hold their values, including arb_valid.
- Requesters keep valid and packet stable until ready is seen.

## Timing
- Grant decision is combinational in cycle T; arb_* and perf_* register at the end of T and are visible in T+1. Latency is 1 cycle.
- With stall = 0 and no grant in T, arb_valid = 0 in T+1, and perf pulses are 0.
- A stall asserted in T freezes the outputs captured at the end of T-1.
- Throughput: one grant per unstalled cycle.
- Reset (asynchronous, any cycle, including mid-burst) forces to 0:
  - arb_valid, arb_packet, arb_data, arb_is_fill, arb_is_restarted_flush, arb_source;
  - perf_core_grant, perf_restart_grant;
  - rr_ptr, burst_cnt.
  - Readies are 0 while reset is held. The first grant after release is scanned from core 0.
- Simultaneous restart and core requests resolve per the rule above within the same cycle. Exactly one source is granted.

## Test plan
- N=4, all cores valid continuously, no restart, stall=0 → grants 0,1,2,3,0,…; arb_source follows in T+1; one req_ready bit high per cycle.
- N=3 (non-power-of-two), rr_ptr=2 and only core 2 valid → grant 2; rr_ptr wraps to 0; next scan grants core 0 first when cores 0 and 2 are valid.
- RESTART_BURST_MAX=4, restart_valid and core 1 valid continuously → grants R,R,R,R,C1,R,R,R,R,C1; arb_is_fill=1 and arb_data=restart_data on the R cycles.
- Restart alone with restart_is_flush=1 for 10 cycles → 10 consecutive restart grants; arb_is_restarted_flush=1; arb_source=0; perf_restart_grant pulses every cycle.
- Stall high for 3 cycles while cores 0 and 2 are valid → readies 0; arb_* hold their previous grant; after release, core 0 or 2 is granted per the unchanged rr_ptr.
- Reset asserted mid-burst (burst_cnt=3, arb_valid=1) → outputs 0 immediately without waiting for a clock edge; after release, the first core grant is from core 0, and a restart with a pending core is granted 4 times before the forced core grant.

Source files
------------

// File: rtl/l2_request_arbiter.sv
// L2 pipeline head: picks one request per cycle from N core ports (round-robin)
// or the memory restart port (priority, burst-limited) and registers it for the tag stage.
module l2_request_arbiter #(
    parameter int NUM_REQUESTERS    = 4,
    parameter int PACKET_WIDTH      = 128,
    parameter int DATA_WIDTH        = 512,
    parameter int RESTART_BURST_MAX = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQUESTERS-1:0]               req_valid,
    input  logic [NUM_REQUESTERS*PACKET_WIDTH-1:0]  req_packet,
    output logic [NUM_REQUESTERS-1:0]               req_ready,
    input  logic                                    restart_valid,
    input  logic [PACKET_WIDTH-1:0]                 restart_packet,
    input  logic [DATA_WIDTH-1:0]                   restart_data,
    input  logic                                    restart_is_flush,
    output logic                                    restart_ready,
    input  logic                                    stall,
    output logic                                    arb_valid,
    output logic [PACKET_WIDTH-1:0]                 arb_packet,
    output logic [DATA_WIDTH-1:0]                   arb_data,
    output logic                                    arb_is_fill,
    output logic                                    arb_is_restarted_flush,
    output logic [((NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1)-1:0] arb_source,
    output logic                                    perf_core_grant,
    output logic                                    perf_restart_grant
);

    localparam int SRC_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int CNT_W = $clog2(RESTART_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(RESTART_BURST_MAX);
    localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQUESTERS - 1);

    logic [SRC_W-1:0]        r_rr_ptr;
    logic [CNT_W-1:0]        r_burst_cnt;

    logic                    r_vld_p1;
    logic [PACKET_WIDTH-1:0] r_packet_p1;
    logic [DATA_WIDTH-1:0]   r_data_p1;
    logic                    r_is_fill_p1;
    logic                    r_is_flush_p1;
    logic [SRC_W-1:0]        r_source_p1;
    logic                    r_perf_core_p1;
    logic                    r_perf_restart_p1;

    logic                    w_core_pending;
    logic                    w_force_core;
    logic                    w_grant_restart;
    logic                    w_grant_core;
    logic                    w_core_found;
    logic [SRC_W-1:0]        w_core_idx;
    logic [SRC_W-1:0]        w_ptr_next;
    logic [PACKET_WIDTH-1:0] w_core_packet;

    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQUESTERS) sum = sum - NUM_REQUESTERS;
        return sum[SRC_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == BURST_MAX) ? cnt : cnt + 1'b1;
    endfunction

    assign w_core_pending  = |req_valid;
    assign w_force_core    = (r_burst_cnt == BURST_MAX) && w_core_pending;
    assign w_grant_restart = restart_valid && !w_force_core;
    assign w_grant_core    = !w_grant_restart && w_core_found;

    // Scan starts at rr_ptr and wraps modulo N, so any N works, not just powers of two.
    always_comb begin
        w_core_found = 1'b0;
        w_core_idx   = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (!w_core_found && req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_core_found = 1'b1;
                w_core_idx   = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_ptr_next    = (w_core_idx == LAST_IDX) ? '0 : w_core_idx + 1'b1;
    assign w_core_packet = req_packet[int'(w_core_idx)*PACKET_WIDTH +: PACKET_WIDTH];

    always_comb begin
        req_ready = '0;
        if (!reset && !stall && w_grant_core) req_ready[w_core_idx] = 1'b1;
    end

    assign restart_ready = !reset && !stall && w_grant_restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else if (!stall) begin
            if (w_grant_restart) begin
                r_burst_cnt <= sat_inc(r_burst_cnt);
            end else if (w_grant_core) begin
                r_burst_cnt <= '0;
                r_rr_ptr    <= w_ptr_next;
            end else if (!restart_valid) begin
                r_burst_cnt <= '0;
            end
        end
    end

    // Stage p0 -> p1: register the granted request; stall freezes the whole stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1          <= 1'b0;
            r_packet_p1       <= '0;
            r_data_p1         <= '0;
            r_is_fill_p1      <= 1'b0;
            r_is_flush_p1     <= 1'b0;
            r_source_p1       <= '0;
            r_perf_core_p1    <= 1'b0;
            r_perf_restart_p1 <= 1'b0;
        end else if (!stall) begin
            r_vld_p1          <= w_grant_restart || w_grant_core;
            r_perf_core_p1    <= w_grant_core;
            r_perf_restart_p1 <= w_grant_restart;
            r_is_fill_p1      <= w_grant_restart;
            r_is_flush_p1     <= w_grant_restart && restart_is_flush;
            if (w_grant_restart) begin
                r_packet_p1 <= restart_packet;
                r_data_p1   <= restart_data;
                r_source_p1 <= '0;
            end else if (w_grant_core) begin
                r_packet_p1 <= w_core_packet;
                r_data_p1   <= '0;
                r_source_p1 <= w_core_idx;
            end else begin
                r_packet_p1 <= '0;
                r_data_p1   <= '0;
                r_source_p1 <= '0;
            end
        end
    end

    assign arb_valid              = r_vld_p1;
    assign arb_packet             = r_packet_p1;
    assign arb_data               = r_data_p1;
    assign arb_is_fill            = r_is_fill_p1;
    assign arb_is_restarted_flush = r_is_flush_p1;
    assign arb_source             = r_source_p1;
    assign perf_core_grant        = r_perf_core_p1;
    assign perf_restart_grant     = r_perf_restart_p1;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: N=4 main instance plus an N=3 instance for wrap checks.
module tb_l2_request_arbiter;

    localparam int N  = 4;
    localparam int PW = 128;
    localparam int DW = 512;
    localparam int BM = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N*PW-1:0] req_packet;
    logic [N-1:0]    req_ready;
    logic            restart_valid;
    logic [PW-1:0]   restart_packet;
    logic [DW-1:0]   restart_data;
    logic            restart_is_flush;
    logic            restart_ready;
    logic            stall;
    logic            arb_valid;
    logic [PW-1:0]   arb_packet;
    logic [DW-1:0]   arb_data;
    logic            arb_is_fill;
    logic            arb_is_restarted_flush;
    logic [1:0]      arb_source;
    logic            perf_core_grant;
    logic            perf_restart_grant;

    logic [2:0]  r3_valid;
    logic [23:0] r3_packet;
    logic [2:0]  r3_ready;
    logic        r3_rst_valid;
    logic [7:0]  r3_rst_packet;
    logic [7:0]  r3_rst_data;
    logic        r3_rst_flush;
    logic        r3_rst_ready;
    logic        r3_arb_valid;
    logic [7:0]  r3_arb_packet;
    logic [7:0]  r3_arb_data;
    logic        r3_arb_fill;
    logic        r3_arb_flush;
    logic [1:0]  r3_arb_source;
    logic        r3_perf_core;
    logic        r3_perf_restart;

    l2_request_arbiter #(
        .NUM_REQUESTERS(N), .PACKET_WIDTH(PW), .DATA_WIDTH(DW), .RESTART_BURST_MAX(BM)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_packet(req_packet), .req_ready(req_ready),
        .restart_valid(restart_valid), .restart_packet(restart_packet),
        .restart_data(restart_data), .restart_is_flush(restart_is_flush),
        .restart_ready(restart_ready), .stall(stall),
        .arb_valid(arb_valid), .arb_packet(arb_packet), .arb_data(arb_data),
        .arb_is_fill(arb_is_fill), .arb_is_restarted_flush(arb_is_restarted_flush),
        .arb_source(arb_source), .perf_core_grant(perf_core_grant),
        .perf_restart_grant(perf_restart_grant)
    );

    l2_request_arbiter #(
        .NUM_REQUESTERS(3), .PACKET_WIDTH(8), .DATA_WIDTH(8), .RESTART_BURST_MAX(2)
    ) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(r3_valid), .req_packet(r3_packet), .req_ready(r3_ready),
        .restart_valid(r3_rst_valid), .restart_packet(r3_rst_packet),
        .restart_data(r3_rst_data), .restart_is_flush(r3_rst_flush),
        .restart_ready(r3_rst_ready), .stall(1'b0),
        .arb_valid(r3_arb_valid), .arb_packet(r3_arb_packet), .arb_data(r3_arb_data),
        .arb_is_fill(r3_arb_fill), .arb_is_restarted_flush(r3_arb_flush),
        .arb_source(r3_arb_source), .perf_core_grant(r3_perf_core),
        .perf_restart_grant(r3_perf_restart)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pkt(input int i);
        return PW'(128'hC0DE_0000) + PW'(i);
    endfunction

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_ready;
        logic         is_r;
        int           src;

        reset            = 1'b1;
        stall            = 1'b0;
        req_valid        = 4'hF;
        restart_valid    = 1'b1;
        restart_is_flush = 1'b0;
        restart_packet   = 128'hFEED_0001;
        restart_data     = {16{32'h1234_5678}};
        for (int i = 0; i < N; i++) req_packet[i*PW +: PW] = pkt(i);
        r3_valid      = '0;
        r3_packet     = {8'h22, 8'h11, 8'h00};
        r3_rst_valid  = 1'b0;
        r3_rst_packet = '0;
        r3_rst_data   = '0;
        r3_rst_flush  = 1'b0;

        // Reset state, readies held low even with requests present
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_restart_ready", restart_ready, 0);
        chk("rst_arb_valid", arb_valid, 0);
        chk("rst_arb_packet", arb_packet, 0);
        chk("rst_arb_source", arb_source, 0);
        chk("rst_perf", {perf_core_grant, perf_restart_grant}, 0);

        // Round-robin over all four cores
        reset         = 1'b0;
        restart_valid = 1'b0;
        req_valid     = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_ready = 4'(1) << (k % 4);
            chk("rr_req_ready", req_ready, exp_ready);
            chk("rr_restart_ready", restart_ready, 0);
            edge_sample();
            chk("rr_arb_valid", arb_valid, 1);
            chk("rr_arb_source", arb_source, k % 4);
            chk("rr_arb_packet", arb_packet, pkt(k % 4));
            chk("rr_arb_fill_data", {arb_is_fill, arb_data}, 0);
            chk("rr_perf", {perf_core_grant, perf_restart_grant}, 2'b10);
        end

        // Restart burst limit against a pending core 1
        req_valid     = 4'b0010;
        restart_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            is_r = ((k % 5) != 4);
            #1;
            chk("burst_restart_ready", restart_ready, is_r);
            chk("burst_req_ready", req_ready, is_r ? 4'b0000 : 4'b0010);
            edge_sample();
            chk("burst_arb_is_fill", arb_is_fill, is_r);
            chk("burst_arb_data", arb_data, is_r ? restart_data : '0);
            chk("burst_arb_source", arb_source, is_r ? 0 : 1);
            chk("burst_arb_packet", arb_packet, is_r ? restart_packet : pkt(1));
            chk("burst_perf", {perf_core_grant, perf_restart_grant}, is_r ? 2'b01 : 2'b10);
        end

        // Restart alone, flush completions, never throttled
        req_valid        = 4'b0000;
        restart_is_flush = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("flush_restart_ready", restart_ready, 1);
            edge_sample();
            chk("flush_arb_valid", arb_valid, 1);
            chk("flush_arb_flag", arb_is_restarted_flush, 1);
            chk("flush_arb_source", arb_source, 0);
            chk("flush_perf", {perf_core_grant, perf_restart_grant}, 2'b01);
        end

        // Idle cycle: no grant, no pulses
        restart_valid    = 1'b0;
        restart_is_flush = 1'b0;
        #1;
        chk("idle_restart_ready", restart_ready, 0);
        edge_sample();
        chk("idle_arb_valid", arb_valid, 0);
        chk("idle_perf", {perf_core_grant, perf_restart_grant}, 0);

        // Stall: rr_ptr is 2 here, cores 0 and 2 requesting
        req_valid = 4'b0101;
        #1;
        chk("pre_stall_ready", req_ready, 4'b0100);
        edge_sample();
        chk("pre_stall_source", arb_source, 2);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_req_ready", req_ready, 0);
            chk("stall_restart_ready", restart_ready, 0);
            edge_sample();
            chk("stall_arb_valid", arb_valid, 1);
            chk("stall_arb_source", arb_source, 2);
            chk("stall_arb_packet", arb_packet, pkt(2));
            chk("stall_perf_core", perf_core_grant, 1);
        end
        stall = 1'b0;
        #1;
        chk("post_stall_ready", req_ready, 4'b0001);
        edge_sample();
        chk("post_stall_source", arb_source, 0);
        chk("post_stall_packet", arb_packet, pkt(0));

        // Reset mid-burst: three restart grants, then asynchronous reset
        req_valid     = 4'b1000;
        restart_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            edge_sample();
            chk("preburst_arb_is_fill", arb_is_fill, 1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async_arb_valid", arb_valid, 0);
        chk("async_arb_fill", arb_is_fill, 0);
        chk("async_arb_data", arb_data, 0);
        chk("async_arb_packet", arb_packet, 0);
        chk("async_perf", {perf_core_grant, perf_restart_grant}, 0);
        chk("async_readies", {req_ready, restart_ready}, 0);
        edge_sample();
        reset         = 1'b0;
        restart_valid = 1'b0;
        req_valid     = 4'hF;
        #1;
        chk("after_rst_ready", req_ready, 4'b0001);
        edge_sample();
        chk("after_rst_source", arb_source, 0);

        // Burst counter restarted from 0: R,R,R,R then forced core 1
        req_valid     = 4'b0010;
        restart_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            is_r = (k != 4);
            #1;
            chk("rburst_restart_ready", restart_ready, is_r);
            edge_sample();
            chk("rburst_arb_is_fill", arb_is_fill, is_r);
            src = is_r ? 0 : 1;
            chk("rburst_arb_source", arb_source, src);
        end
        restart_valid = 1'b0;
        req_valid     = 4'b0000;

        // N=3: reach rr_ptr=2, wrap to 0
        r3_valid = 3'b010;
        #1;
        chk("n3_ready_c1", r3_ready, 3'b010);
        edge_sample();
        chk("n3_source_c1", r3_arb_source, 1);
        r3_valid = 3'b100;
        #1;
        chk("n3_ready_c2", r3_ready, 3'b100);
        edge_sample();
        chk("n3_source_c2", r3_arb_source, 2);
        chk("n3_packet_c2", r3_arb_packet, 8'h22);
        r3_valid = 3'b101;
        #1;
        chk("n3_ready_wrap", r3_ready, 3'b001);
        edge_sample();
        chk("n3_source_wrap", r3_arb_source, 0);
        chk("n3_valid_wrap", r3_arb_valid, 1);
        r3_valid = 3'b000;
        edge_sample();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
